// File: rtl/idct8_serial.sv
// idct8_serial: serial 8-point 1-D inverse DCT on one shared multiply-accumulate unit.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_data take X0..X7 (Q11.4);
// out_valid/out_ready/out_data/out_last return x0..x7 (Q11.4), out_last high with x7.
// Define IDCT_SAT_EN to clamp results to 16 bits; otherwise they wrap.
module idct8_serial #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int ACC_W = 35
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);
  typedef enum logic [1:0] {LOAD, CALC, SEND} state_t;
  state_t state, state_n;
  logic [2:0] kin, k, n;
  logic signed [DATA_W-1:0] xm [8];
  logic signed [ACC_W-1:0] acc, acc_sum;
  logic signed [COEF_W-1:0] coef;
  logic signed [DATA_W+COEF_W-1:0] prod;
  logic [DATA_W-1:0] res;
  logic in_fire, out_fire;
`ifdef IDCT_SAT_EN
  logic signed [ACC_W-1:0] rnd;
`endif
  // Cosine index m = (2n+1)k mod 32 folds onto one quarter wave; for k>0 m never
  // lands on a multiple of 8, so index 0 only occurs for the DC row.
  function automatic logic signed [COEF_W-1:0] coef_rom(input logic [2:0] kk, input logic [2:0] nn);
    logic [4:0] m;
    logic [3:0] j;
    logic [COEF_W-1:0] mag;
    m = {1'b0, nn, 1'b1} * {2'b0, kk};
    j = m[3] ? 4'd0 - m[3:0] : m[3:0];
    case (j[2:0])
      3'd1: mag = 16'd8035;
      3'd2: mag = 16'd7568;
      3'd3: mag = 16'd6811;
      3'd4: mag = 16'd5793;
      3'd5: mag = 16'd4551;
      3'd6: mag = 16'd3135;
      3'd7: mag = 16'd1598;
      default: mag = 16'd5793;
    endcase
    return (m[4] ^ m[3]) ? -mag : mag;
  endfunction
  always_comb begin
    in_ready = state == LOAD;
    out_valid = state == SEND;
    out_last = out_valid && n == 3'd7;
    in_fire = in_ready && in_valid;
    out_fire = out_valid && out_ready;
    coef = coef_rom(k, n);
    prod = xm[k] * coef;
    acc_sum = acc + ACC_W'(prod);
`ifdef IDCT_SAT_EN
    rnd = (acc_sum + ACC_W'(8192)) >>> 14;
    res = rnd > 32767 ? 16'h7fff : rnd < -32768 ? 16'h8000 : rnd[15:0];
`else
    res = DATA_W'((acc_sum + ACC_W'(8192)) >>> 14);
`endif
    state_n = (in_fire && kin == 3'd7) ? CALC :
              (state == CALC && k == 3'd7) ? SEND :
              out_fire ? (n == 3'd7 ? LOAD : CALC) : state;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      kin <= '0;
      k <= '0;
      n <= '0;
      acc <= '0;
      out_data <= '0;
    end else begin
      if (in_fire) begin
        xm[kin] <= in_data;
        kin <= kin + 3'd1;
      end
      if (in_fire && kin == 3'd7) begin
        n <= '0;
        k <= '0;
        acc <= '0;
      end
      if (state == CALC) begin
        acc <= acc_sum;
        k <= k + 3'd1;
      end
      if (state == CALC && k == 3'd7) out_data <= res;
      if (out_fire) begin
        n <= n + 3'd1;
        acc <= '0;
      end
    end
  end
endmodule

// File: tb/tb_idct8_serial.sv
// tb_idct8_serial: randomized and directed bench for idct8_serial against a real-arithmetic IDCT model.
module tb_idct8_serial;
  logic clk = 0, rst = 1, in_valid = 0, out_ready, out_valid, out_last, in_ready;
  logic [15:0] in_data = 0, out_data;
  logic rr = 0, rnd_bit = 1, man_ready = 1;
  int tests = 0, fails = 0, cyc = 0;
  logic [15:0] q[$];
  logic [15:0] win[8];
  int in_cnt = 0, pos = 0, last_acc = 0;
  bit busy = 0, prev_v = 0;

  assign out_ready = rr ? rnd_bit : man_ready;

  idct8_serial dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
                    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge clk) begin
    #1 rnd_bit = $urandom_range(0, 3) != 0;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Direct evaluation of x[n] = sum_k X[k] * round(8192 * c(k) * cos((2n+1)k*pi/16)), then Q-shift.
  function automatic logic [15:0] idct_ref(input logic [15:0] w[8], input int n);
    longint acc = 0, r;
    real ck, c;
    for (int kk = 0; kk < 8; kk++) begin
      ck = (kk == 0) ? 1.0 / $sqrt(2.0) : 1.0;
      c = $floor(16384.0 * 0.5 * ck * $cos((2 * n + 1) * kk * 3.14159265358979 / 16.0) + 0.5);
      acc += longint'($signed(w[kk])) * longint'(c);
    end
    r = (acc + 8192) >>> 14;
`ifdef IDCT_SAT_EN
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
`endif
    return r[15:0];
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      in_cnt = 0;
      pos = 0;
      busy = 0;
      prev_v = 0;
    end else begin
      chk("in_ready", in_ready, !busy);
      if (!busy && out_valid) chk("spurious_out_valid", 1, 0);
      if (out_valid) begin
        if (!prev_v) chk("out_latency", cyc - last_acc, 8);
        if (q.size() == 0) chk("out_without_expectation", 1, 0);
        else begin
          chk("out_data", out_data, q[0]);
          chk("out_last", out_last, pos == 7);
        end
        if (out_ready) begin
          last_acc = cyc + 1;
          if (q.size() != 0) void'(q.pop_front());
          pos = (pos + 1) % 8;
          if (pos == 0) busy = 0;
        end
      end
      prev_v = out_valid;
      if (in_valid && in_ready) begin
        win[in_cnt] = in_data;
        in_cnt++;
        if (in_cnt == 8) begin
          in_cnt = 0;
          busy = 1;
          last_acc = cyc + 1;
          for (int i = 0; i < 8; i++) q.push_back(idct_ref(win, i));
        end
      end
    end
  end

  task automatic send_block(input logic [15:0] w[8], input int gpos, input int glen);
    bit ok;
    int t;
    for (int i = 0; i < 8; i++) begin
      if (i == gpos) begin
        in_valid = 0;
        repeat (glen) @(posedge clk);
        #1;
      end
      in_valid = 1;
      in_data = w[i];
      t = 0;
      do begin
        @(negedge clk);
        ok = in_ready;
        @(posedge clk);
        #1;
        t++;
      end while (!ok && t < 2000);
      if (!ok) chk("in_ready_timeout", 0, 1);
    end
    in_valid = 0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((busy || q.size() != 0) && t < 3000) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 3000) chk("block_timeout", 0, 1);
  endtask

  task automatic wait_for(input int p, input bit v);
    int t = 0;
    while (!(out_valid == v && pos == p && busy) && t < 2000) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 2000) chk("wait_timeout", 0, 1);
  endtask

  initial begin
    logic [15:0] dc[8], neg[8], big[8], w[8];
    for (int i = 0; i < 8; i++) begin
      dc[i] = (i == 0) ? 16'h0100 : 16'h0000;
      neg[i] = (i == 0) ? 16'hFEC0 : 16'h0000;
      big[i] = 16'h7FFF;
    end
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_out_last", out_last, 0);
    chk("model_dc_pos", idct_ref(dc, 0), 16'h005B);
    chk("model_dc_pos_x5", idct_ref(dc, 5), 16'h005B);
    chk("model_dc_neg", idct_ref(neg, 7), 16'hFF8F);
`ifdef IDCT_SAT_EN
    chk("model_overflow", idct_ref(big, 0), 16'h7FFF);
`else
    chk("model_overflow", idct_ref(big, 0), 16'h5225);
`endif
    @(posedge clk);
    #1;
    send_block(dc, -1, 0);
    wait_for(3, 1);
    man_ready = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_data", out_data, 16'h005B);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_position", pos, 3);
    end
    man_ready = 1;
    wait_idle();
    send_block(neg, -1, 0);
    wait_idle();
    send_block(dc, 3, 3);
    wait_idle();
    send_block(big, -1, 0);
    wait_idle();
    send_block(dc, -1, 0);
    wait_for(2, 0);
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", out_data, 0);
    send_block(dc, -1, 0);
    wait_idle();
    rr = 1;
    for (int b = 0; b < 24; b++) begin
      for (int i = 0; i < 8; i++) w[i] = (b % 3 == 0) ? 16'($urandom) : 16'($signed($urandom_range(0, 4095)) - 2048);
      send_block(w, $urandom_range(0, 9), $urandom_range(0, 4));
    end
    wait_idle();
    rr = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/idct8_serial.md
# idct8_serial

Serial 8-point 1-D inverse DCT, the decode-side counterpart of the forward DCT row/column datapath. It accepts one block of 8 DCT coefficients X0..X7 in 16-bit Q11.4 two's complement. It returns 8 spatial samples x0..x7 in the same format. The block is built from a single shared multiply-accumulate unit, and two passes through it with a transpose form the 2-D IDCT.

## Interface
Parameters:
- DATA_W, 16, sample width; Q11.4 two's complement. Fixed; other values unsupported.
- COEF_W, 16, ROM coefficient width; Q1.14 signed.
- ACC_W, 35, accumulator width; holds 8 products of 32 bits.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  coefficient word valid.
- in_ready  out  1  block can accept a coefficient.
- in_data  in  16  coefficient Xk, Q11.4, order k=0..7.
- out_valid  out  1  sample valid.
- out_ready  in  1  downstream accepts the sample.
- out_data  out  16  sample xn, Q11.4, order n=0..7.
- out_last  out  1  high with x7.

## Operation
- Transfers: an input transfer happens when in_valid and in_ready are both high at a clk edge. An output transfer happens when out_valid and out_ready are both high at a clk edge.
- States:
  - LOAD: in_ready=1. Each transfer writes in_data to X[kin] and increments kin. The transfer with kin=7 clears kin and n, clears acc, and moves to CALC.
  - CALC: in_ready=0, out_valid=0. One MAC per cycle: acc += X[k]·C[k][n], for k=0..7. After the k=7 MAC the state moves to SEND and out_data is registered from the rounded acc.
  - SEND: out_valid=1, and out_last=1 when n=7. On an output transfer:
    - if n<7: n++, acc cleared, go to CALC;
    - if n=7: go to LOAD.
- Coefficient ROM: C[k][n] = round(16384 · 0.5 · c(k) · cos((2n+1)kπ/16)), where c(0)=1/√2 and c(k>0)=1.
  - Magnitudes for k=0..7: 5793, 8035, 7568, 6811, 5793, 4551, 3135, 1598. The sign follows the cosine.
- Arithmetic:
  - Product is 16×16 signed, giving 32 bits in Q12.18. It is sign-extended to ACC_W.
  - Output = (acc + 8192) >>> 14, i.e. round half toward +∞ with an arithmetic shift, then reduced to 16 bits (see Configuration).
- Boundaries:
  - in_valid is ignored outside LOAD.
  - out_ready is ignored outside SEND.
  - out_data holds its value while out_valid=1 and out_ready=0.
  - rst at any state (mid-LOAD, mid-CALC, mid-SEND) discards the partial block. The state goes to LOAD with kin=0 and n=0; no sample is emitted.
  - Inputs may arrive with gaps; kin persists across idle cycles.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, out_last=0, with state=LOAD, kin=0, n=0, acc=0.
- LOAD: throughput of one coefficient per cycle.
- First sample latency: out_valid rises 8 cycles after the edge that accepts X7.
- Subsequent samples: out_valid rises 8 cycles after each accepting output edge. There is 1 bubble cycle minimum in CALC ordering; 9 cycles per sample with out_ready held high.
- Block period: 8 load + 8×9 compute/send = 80 cycles minimum.
- in_ready rises in the cycle after the x7 transfer.

## Configuration
- IDCT_SAT_EN defined: the rounded result is clamped to [−32768, 32767], i.e. 0x8000..0x7FFF.
- IDCT_SAT_EN undefined: the rounded result is truncated to bits [15:0] (two's-complement wrap), and no clamp logic is built.

## Test plan
- DC positive: X0=0x0100 (16.0), X1..X7=0 -> eight samples, each 0x005B; out_last only on the 8th.
- DC negative: X0=0xFEC0 (−20.0), rest 0 -> eight samples, each 0xFF8F.
- Overflow: X0..X7=0x7FFF -> x0=0x7FFF with IDCT_SAT_EN; x0=0x5225 without it.
- Backpressure: during the DC positive case, hold out_ready=0 for 5 cycles at x3 -> out_valid stays 1, out_data stays 0x005B, in_ready stays 0, n does not advance.
- Gapped input: same block with in_valid low for 3 cycles between X2 and X3 -> outputs identical to the DC positive case; out_valid first rises 8 cycles after X7 is accepted.
- Reset mid-operation: assert rst for 1 cycle during CALC of x2 -> next cycle in_ready=1, out_valid=0, out_data=0. A fresh DC positive block then yields eight samples of 0x005B.
